seven_seg_round_decoder: RTL and testbench
==========================================

# seven_seg_round_decoder

Decoder for the three-digit seven-segment round-number display: captures the three active-low digit patterns that drive the round display, decodes them hundreds-first over three cycles into a binary value, and returns it on a valid/ready output with error flags. Sits on the display bus as a loopback checker and readback path, so the game controller and benches can confirm what the round display actually shows.

## Interface
- No parameters.
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  capture request; sampled only in IDLE
- display0  in  [0:6]  units pattern, bit0=seg a … bit6=seg g, active-low
- display1  in  [0:6]  tens pattern, same encoding
- display2  in  [0:6]  hundreds pattern, same encoding
- busy  out  1  high whenever state ≠ IDLE
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- value  out  10  decoded binary value, 0–999
- err  out  2  bit0 = non-digit/non-dash pattern seen; bit1 = dash seen or range violation

## Operation
- Digit codes (active-low, a..g): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100; dash=1111110. Any other pattern is invalid.
- States: IDLE, DIG2, DIG1, DIG0, DONE.
- IDLE: on start=1, register all three patterns into capture registers, clear accumulator and error bits, go to DIG2. Later changes on display* do not affect the transaction.
- DIG2/DIG1/DIG0: decode the captured hundreds/tens/units pattern; acc ← acc*10 + digit (intermediate 14 bits, result fits 10 bits, max 999). Invalid pattern: set err bit0 and contribute 0. Dash: set err bit1 and contribute 0.
- Leaving DIG0: load value, err, and out_valid=1, then go to DONE. When any err bit is set, value is forced to 0.
- DONE: hold value, err, and out_valid stable until out_ready=1 is sampled. Then out_valid←0 and go to IDLE. start is ignored in every state except IDLE.
- Reset (any state, asynchronous): state=IDLE, busy=0, out_valid=0, value=0, err=2'b00, capture registers and accumulator cleared. An in-flight transaction is discarded.

## Timing
- start sampled at edge E0 → DIG2 during E0–E1, DIG1 during E1–E2, DIG0 during E2–E3. out_valid=1 from edge E3, giving a latency of 3 cycles.
- busy rises at E0 and falls on the edge where out_valid&&out_ready is sampled.
- out_ready tied high: out_valid lasts one cycle. The earliest next start is sampled one cycle after that, so throughput is one result per 5 cycles.
- out_ready may be high before out_valid; it has no effect outside DONE.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- SEG_DEC_RANGE_CHECK_EN defined: after DIG0, a decoded value > 100 sets err bit1 and forces value=0. This matches the display's legal 0–100 range.
- Undefined: values 101–999 pass through with err bit1 clear, unless a dash was seen. Dash and invalid-pattern detection are unaffected by the macro.

## Structure
- Shared package seg_pkg: the eleven segment-pattern constants (SEG_0…SEG_9, SEG_DASH), the state enum type, and the constant ROUND_MAX=100. The existing display encoder imports the same constants.
- One sub-module, seg_digit_decode: combinational, 7-bit pattern → 4-bit digit, is_digit, is_dash. It is instantiated once and muxed by state.

## Test plan
- display2=0000001, display1=0010010, display0=1001111, start pulse → out_valid at 3rd edge after start, value=21, err=00.
- Patterns for 1,0,0 → value=100, err=00; all three 0000001 → value=0, err=00.
- All three 1111110 (the display's >100 indication) → value=0, err=10.
- display1=1111111 (invalid), others valid → value=0, err=01; display1 dash plus display0 1111111 → err=11.
- Patterns 1,0,1 → value=0, err=10 with SEG_DEC_RANGE_CHECK_EN; value=101, err=00 without it.
- Hold out_ready=0 for 5 cycles in DONE while pulsing start and changing display* → value/err/out_valid stable, no new capture. Then out_ready=1 → IDLE next cycle. Assert rst during DIG1 → all outputs 0 immediately, and the next start decodes correctly.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: segment pattern constants, decoder state type and round-range limit
package seg_pkg;
  localparam logic [0:6] SEG_0    = 7'b0000001;
  localparam logic [0:6] SEG_1    = 7'b1001111;
  localparam logic [0:6] SEG_2    = 7'b0010010;
  localparam logic [0:6] SEG_3    = 7'b0000110;
  localparam logic [0:6] SEG_4    = 7'b1001100;
  localparam logic [0:6] SEG_5    = 7'b0100100;
  localparam logic [0:6] SEG_6    = 7'b0100000;
  localparam logic [0:6] SEG_7    = 7'b0001111;
  localparam logic [0:6] SEG_8    = 7'b0000000;
  localparam logic [0:6] SEG_9    = 7'b0001100;
  localparam logic [0:6] SEG_DASH = 7'b1111110;
  localparam logic [9:0] ROUND_MAX = 10'd100;
  typedef enum logic [2:0] {IDLE, DIG2, DIG1, DIG0, DONE} state_t;
endpackage

// File: rtl/seg_digit_decode.sv
// seg_digit_decode: active-low 7-segment pattern (bit0=a..bit6=g) to digit
// pat in [0:6]; digit out [3:0] (0 when not a digit); is_digit, is_dash out.
module seg_digit_decode
  import seg_pkg::*;
(
  input  logic [0:6] pat,
  output logic [3:0] digit,
  output logic       is_digit,
  output logic       is_dash
);
  always_comb begin
    digit = 4'd0;
    is_digit = 1'b1;
    is_dash = 1'b0;
    case (pat)
      SEG_0: digit = 4'd0;
      SEG_1: digit = 4'd1;
      SEG_2: digit = 4'd2;
      SEG_3: digit = 4'd3;
      SEG_4: digit = 4'd4;
      SEG_5: digit = 4'd5;
      SEG_6: digit = 4'd6;
      SEG_7: digit = 4'd7;
      SEG_8: digit = 4'd8;
      SEG_9: digit = 4'd9;
      SEG_DASH: begin
        is_digit = 1'b0;
        is_dash = 1'b1;
      end
      default: is_digit = 1'b0;
    endcase
  end
endmodule

// File: rtl/seven_seg_round_decoder.sv
// seven_seg_round_decoder: reads back the 3-digit round display as a binary value
// clk, rst (async active-high); start captures display2/1/0 (hundreds/tens/units,
// active-low a..g); busy while not IDLE; out_valid/out_ready handshake for
// value[9:0] and err[1:0] (bit0 invalid pattern, bit1 dash or range violation).
// Optional macro SEG_DEC_RANGE_CHECK_EN: results above ROUND_MAX flag err bit1.
module seven_seg_round_decoder
  import seg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [0:6] display0,
  input  logic [0:6] display1,
  input  logic [0:6] display2,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [9:0] value,
  output logic [1:0] err
);
  state_t state_q, state_d;
  logic [0:6] cap0_q, cap0_d, cap1_q, cap1_d, cap2_q, cap2_d, pat;
  logic [13:0] acc_q, acc_d, acc_next;
  logic [1:0] acc_err_q, acc_err_d, dig_err, fin_err, err_q, err_d;
  logic [9:0] value_q, value_d;
  logic valid_q, valid_d, is_digit, is_dash;
  logic [3:0] digit;
  seg_digit_decode u_dec (.pat(pat), .digit(digit), .is_digit(is_digit), .is_dash(is_dash));
  assign pat = state_q == DIG2 ? cap2_q : state_q == DIG1 ? cap1_q : cap0_q;
  assign acc_next = acc_q * 14'd10 + {10'd0, is_digit ? digit : 4'd0};
  assign dig_err = acc_err_q | {is_dash, ~is_digit & ~is_dash};
`ifdef SEG_DEC_RANGE_CHECK_EN
  assign fin_err = dig_err | {acc_next > {4'd0, ROUND_MAX}, 1'b0};
`else
  assign fin_err = dig_err;
`endif
  always_comb begin
    state_d = state_q;
    cap0_d = cap0_q;
    cap1_d = cap1_q;
    cap2_d = cap2_q;
    acc_d = acc_q;
    acc_err_d = acc_err_q;
    value_d = value_q;
    err_d = err_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: if (start) begin
        cap0_d = display0;
        cap1_d = display1;
        cap2_d = display2;
        acc_d = '0;
        acc_err_d = '0;
        state_d = DIG2;
      end
      DIG2, DIG1: begin
        acc_d = acc_next;
        acc_err_d = dig_err;
        state_d = state_q == DIG2 ? DIG1 : DIG0;
      end
      DIG0: begin
        acc_d = acc_next;
        acc_err_d = fin_err;
        value_d = |fin_err ? 10'd0 : acc_next[9:0];
        err_d = fin_err;
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: if (out_ready) begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cap0_q <= '0;
      cap1_q <= '0;
      cap2_q <= '0;
      acc_q <= '0;
      acc_err_q <= '0;
      value_q <= '0;
      err_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cap0_q <= cap0_d;
      cap1_q <= cap1_d;
      cap2_q <= cap2_d;
      acc_q <= acc_d;
      acc_err_q <= acc_err_d;
      value_q <= value_d;
      err_q <= err_d;
      valid_q <= valid_d;
    end
  end
  assign busy = state_q != IDLE;
  assign out_valid = valid_q;
  assign value = value_q;
  assign err = err_q;
endmodule

// File: tb/tb_seven_seg_round_decoder.sv
// tb_seven_seg_round_decoder: directed and random checks against a digit-level model
module tb_seven_seg_round_decoder;
  logic clk = 1'b0, rst, start, out_ready, busy, out_valid;
  logic [0:6] display0, display1, display2;
  logic [9:0] value, exp_v;
  logic [1:0] err, exp_e;
  int checks = 0, errors = 0;
  logic [0:6] tbl [11];
  seven_seg_round_decoder dut (
    .clk(clk), .rst(rst), .start(start), .display0(display0), .display1(display1),
    .display2(display2), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .value(value), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int classify(input logic [0:6] p);
    for (int i = 0; i < 11; i++) if (tbl[i] === p) return i;
    return 11;
  endfunction
  task automatic model(input logic [0:6] p2, p1, p0, output logic [9:0] v, output logic [1:0] e);
    int d[3];
    int sum;
    d[0] = classify(p2);
    d[1] = classify(p1);
    d[2] = classify(p0);
    sum = 0;
    e = 2'b00;
    for (int i = 0; i < 3; i++) begin
      sum = sum * 10 + (d[i] < 10 ? d[i] : 0);
      if (d[i] == 10) e[1] = 1'b1;
      if (d[i] == 11) e[0] = 1'b1;
    end
`ifdef SEG_DEC_RANGE_CHECK_EN
    if (sum > 100) e[1] = 1'b1;
`endif
    v = e != 2'b00 ? 10'd0 : 10'(sum);
  endtask
  task automatic launch(input logic [0:6] p2, p1, p0);
    @(negedge clk);
    display2 = p2;
    display1 = p1;
    display0 = p0;
    start = 1'b1;
    model(p2, p1, p0, exp_v, exp_e);
    @(negedge clk);
    start = 1'b0;
    display2 = 7'($urandom);
    display1 = 7'($urandom);
    display0 = 7'($urandom);
    chk("busy_rise", busy, 1);
    chk("valid_early_e0", out_valid, 0);
    @(negedge clk);
    @(negedge clk);
    chk("valid_early_e2", out_valid, 0);
    @(negedge clk);
    chk("valid_e3", out_valid, 1);
    chk("value", value, exp_v);
    chk("err", err, exp_e);
  endtask
  task automatic finish_txn();
    out_ready = 1'b1;
    @(negedge clk);
    chk("valid_drop", out_valid, 0);
    chk("busy_drop", busy, 0);
    out_ready = 1'b0;
  endtask
  task automatic run_txn(input logic [0:6] p2, p1, p0, input logic early);
    out_ready = early;
    launch(p2, p1, p0);
    finish_txn();
  endtask
  function automatic logic [0:6] rand_pat();
    int k;
    k = $urandom_range(0, 11);
    return k < 11 ? tbl[k] : 7'($urandom);
  endfunction
  initial begin
    tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
            7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100, 7'b1111110};
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    display0 = '0;
    display1 = '0;
    display2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_value", value, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    run_txn(tbl[0], tbl[2], tbl[1], 1'b0);
    chk("dir_21", value, 21);
    run_txn(tbl[1], tbl[0], tbl[0], 1'b0);
    run_txn(tbl[0], tbl[0], tbl[0], 1'b1);
    run_txn(tbl[10], tbl[10], tbl[10], 1'b0);
    chk("dir_dash_err", err, 2'b10);
    run_txn(tbl[3], 7'b1111111, tbl[4], 1'b0);
    chk("dir_inv_err", err, 2'b01);
    run_txn(tbl[3], tbl[10], 7'b1111111, 1'b0);
    chk("dir_both_err", err, 2'b11);
    run_txn(tbl[1], tbl[0], tbl[1], 1'b0);
    run_txn(tbl[9], tbl[9], tbl[9], 1'b1);
    for (int n = 0; n < 40; n++)
      run_txn(rand_pat(), rand_pat(), rand_pat(), 1'($urandom));
    launch(tbl[0], tbl[2], tbl[1]);
    for (int n = 0; n < 5; n++) begin
      start = n[0] ? 1'b0 : 1'b1;
      display2 = rand_pat();
      display1 = rand_pat();
      display0 = rand_pat();
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_value", value, 21);
      chk("hold_err", err, 0);
      chk("hold_busy", busy, 1);
    end
    start = 1'b0;
    finish_txn();
    run_txn(tbl[0], tbl[5], tbl[7], 1'b0);
    chk("post_hold_57", value, 57);
    @(negedge clk);
    display2 = tbl[1];
    display1 = tbl[2];
    display0 = tbl[3];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_value", value, 0);
    chk("arst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    run_txn(tbl[0], tbl[8], tbl[6], 1'b0);
    chk("post_rst_86", value, 86);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
